// File: rtl/sfixed_div_seq_pkg.sv
// sfixed_div_pkg: shared types and elaboration helpers for the sequential
// signed fixed-point divider.
//   state_e          : controller states (IDLE, DIVIDE, DONE)
//   calc_shift/iters : dividend pre-shift and iteration count
//   sat_max/sat_min  : saturation bit patterns for a w-bit signed result
package sfixed_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_e;

    // Left shift of |num| that aligns the quotient to the output fraction.
    function automatic int calc_shift(int num_right, int den_right,
                                      int out_right);
        return out_right + den_right - num_right;
    endfunction

    // One quotient bit per dividend bit.
    function automatic int calc_iters(int num_w, int shift);
        return num_w + shift;
    endfunction

    // Largest positive value of a w-bit two's complement number.
    function automatic logic [63:0] sat_max(int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative w-bit value; as an unsigned number it is also the
    // largest magnitude a negative result may have.
    function automatic logic [63:0] sat_min(int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sfixed_div_seq_if.sv
// sfixed_div_seq_if: operand/result handshake bundle of the divider.
// Ports (bundled signals):
//   in_valid/in_ready, num, den             : operand channel
//   out_valid/out_ready, quot, overflow,
//   div_by_zero                             : result channel
// Modports: master = requester, slave = divider.
interface sfixed_div_seq_if #(
    parameter int NUM_W = 16,
    parameter int DEN_W = 8,
    parameter int OUT_W = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [NUM_W-1:0] num;
    logic [DEN_W-1:0] den;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] quot;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, num, den, out_ready,
        input  in_ready, out_valid, quot, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, num, den, out_ready,
        output in_ready, out_valid, quot, overflow, div_by_zero
    );

endinterface

// File: rtl/sfixed_div_seq_step.sv
// sfixed_div_step: one combinational restoring-division iteration.
// Ports:
//   rem_i : partial remainder (always < |den|)
//   bit_i : next dividend bit, MSB first
//   den_i : divisor magnitude
//   rem_o : updated remainder
//   q_o   : quotient bit produced by this iteration
module sfixed_div_step #(
    parameter int DEN_W = 8
) (
    input  logic [DEN_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [DEN_W-1:0] rem_o,
    output logic             q_o
);

    logic [DEN_W:0]   trial;
    logic [DEN_W-1:0] diff;

    always_comb begin
        trial = {rem_i, bit_i};
        // When the subtraction is taken the result is below den_i, so the
        // low DEN_W bits carry it exactly.
        diff  = trial[DEN_W-1:0] - den_i;
        q_o   = (trial >= {1'b0, den_i});
        rem_o = q_o ? diff : trial[DEN_W-1:0];
    end

endmodule

// File: rtl/sfixed_div_seq.sv
// sfixed_div_seq: sequential signed fixed-point divider, one quotient bit
// per cycle, truncating toward zero with saturation and den==0 flagging.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of sfixed_div_seq_if (operands in, result out)
module sfixed_div_seq
    import sfixed_div_pkg::*;
#(
    parameter int NUM_LEFT  = 7,
    parameter int NUM_RIGHT = 8,
    parameter int DEN_LEFT  = 3,
    parameter int DEN_RIGHT = 4,
    parameter int OUT_LEFT  = 7,
    parameter int OUT_RIGHT = 8
) (
    input logic             clk,
    input logic             reset,
    sfixed_div_seq_if.slave bus
);

    localparam int NUM_W = NUM_LEFT + NUM_RIGHT + 1;
    localparam int DEN_W = DEN_LEFT + DEN_RIGHT + 1;
    localparam int OUT_W = OUT_LEFT + OUT_RIGHT + 1;
    localparam int SHIFT = calc_shift(NUM_RIGHT, DEN_RIGHT, OUT_RIGHT);
    localparam int ITERS = calc_iters(NUM_W, SHIFT);
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam int CW    = ((ITERS > OUT_W) ? ITERS : OUT_W) + 1;

    localparam logic [OUT_W-1:0] Q_MAX   = OUT_W'(sat_max(OUT_W));
    localparam logic [OUT_W-1:0] Q_MIN   = OUT_W'(sat_min(OUT_W));
    localparam logic [CW-1:0]    POS_LIM = CW'(sat_max(OUT_W));
    localparam logic [CW-1:0]    NEG_LIM = CW'(sat_min(OUT_W));
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(ITERS);

    if (SHIFT < 0) begin : g_bad_shift
        $error("sfixed_div_seq: OUT_RIGHT+DEN_RIGHT must be >= NUM_RIGHT");
    end

    state_e           state_q, state_d;
    logic             sign_q, sign_d;
    logic             num_neg_q, num_neg_d;
    logic             den_zero_q, den_zero_d;
    logic [DEN_W-1:0] den_mag_q, den_mag_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [ITERS-1:0] dq_q, dq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] quot_q, quot_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [NUM_W-1:0] num_mag;
    logic [DEN_W-1:0] den_mag;
    logic [DEN_W-1:0] rem_nxt;
    logic             q_bit;
    logic [CW-1:0]    q_ext;
    logic [OUT_W-1:0] q_neg;

    // |most-negative| is representable once the result is read unsigned.
    assign num_mag = bus.num[NUM_W-1] ? (~bus.num + NUM_W'(1)) : bus.num;
    assign den_mag = bus.den[DEN_W-1] ? (~bus.den + DEN_W'(1)) : bus.den;

    // dq_q doubles as dividend and quotient: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    sfixed_div_step #(
        .DEN_W(DEN_W)
    ) u_step (
        .rem_i(rem_q),
        .bit_i(dq_q[ITERS-1]),
        .den_i(den_mag_q),
        .rem_o(rem_nxt),
        .q_o  (q_bit)
    );

    assign q_ext = CW'(dq_q);
    assign q_neg = OUT_W'(0) - q_ext[OUT_W-1:0];

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        num_neg_d  = num_neg_q;
        den_zero_d = den_zero_q;
        den_mag_d  = den_mag_q;
        rem_d      = rem_q;
        dq_d       = dq_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        ovf_d      = ovf_q;
        dbz_d      = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d     = bus.num[NUM_W-1] ^ bus.den[DEN_W-1];
                    num_neg_d  = bus.num[NUM_W-1];
                    den_zero_d = (bus.den == '0);
                    den_mag_d  = den_mag;
                    rem_d      = '0;
                    dq_d       = ITERS'(num_mag) << SHIFT;
                    cnt_d      = '0;
                    state_d    = DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt_q != LAST) begin
                    rem_d = rem_nxt;
                    dq_d  = {dq_q[ITERS-2:0], q_bit};
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                    if (den_zero_q) begin
                        quot_d = num_neg_q ? Q_MIN : Q_MAX;
                        dbz_d  = 1'b1;
                    end else if (!sign_q && (q_ext > POS_LIM)) begin
                        quot_d = Q_MAX;
                        ovf_d  = 1'b1;
                    end else if (sign_q && (q_ext > NEG_LIM)) begin
                        quot_d = Q_MIN;
                        ovf_d  = 1'b1;
                    end else begin
                        quot_d = sign_q ? q_neg : q_ext[OUT_W-1:0];
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            num_neg_q  <= 1'b0;
            den_zero_q <= 1'b0;
            den_mag_q  <= '0;
            rem_q      <= '0;
            dq_q       <= '0;
            cnt_q      <= '0;
            quot_q     <= '0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            num_neg_q  <= num_neg_d;
            den_zero_q <= den_zero_d;
            den_mag_q  <= den_mag_d;
            rem_q      <= rem_d;
            dq_q       <= dq_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            ovf_q      <= ovf_d;
            dbz_q      <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quot        = quot_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_sfixed_div_seq.sv
// tb_sfixed_div_seq: directed vector bench for sfixed_div_seq at the
// default Q7.8 / Q3.4 / Q7.8 formats.
module tb_sfixed_div_seq;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sfixed_div_seq_if #(.NUM_W(16), .DEN_W(8), .OUT_W(16)) bus ();

    sfixed_div_seq dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] num;
        logic [7:0]  den;
        logic [15:0] q;
        logic        ovf;
        logic        dbz;
    } vec_t;

    localparam int NVEC = 13;
    localparam int LAT  = 21;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] n, input logic [7:0] d,
                            input string tag);
        check({tag, "_rdy_pre"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.num      = n;
        bus.den      = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_rdy_drop"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        start_op(v.num, v.den, tag);
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check({tag, "_quot"}, 32'(bus.quot), 32'(v.q));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(v.ovf));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(v.dbz));
        @(posedge clk);
        #1;
        check({tag, "_rdy_post"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_vld_post"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int   lat;
        vec_t v2;

        vecs[0]  = '{16'h0300, 8'h18, 16'h0200, 1'b0, 1'b0};
        vecs[1]  = '{16'hFF00, 8'h08, 16'hFE00, 1'b0, 1'b0};
        vecs[2]  = '{16'h0100, 8'h30, 16'h0055, 1'b0, 1'b0};
        vecs[3]  = '{16'hFF00, 8'h30, 16'hFFAB, 1'b0, 1'b0};
        vecs[4]  = '{16'h6400, 8'h01, 16'h7FFF, 1'b1, 1'b0};
        vecs[5]  = '{16'h9C00, 8'h01, 16'h8000, 1'b1, 1'b0};
        vecs[6]  = '{16'h0100, 8'h00, 16'h7FFF, 1'b0, 1'b1};
        vecs[7]  = '{16'hFF00, 8'h00, 16'h8000, 1'b0, 1'b1};
        vecs[8]  = '{16'h8000, 8'h10, 16'h8000, 1'b0, 1'b0};
        vecs[9]  = '{16'h7FFF, 8'h10, 16'h7FFF, 1'b0, 1'b0};
        vecs[10] = '{16'h0100, 8'hD0, 16'hFFAB, 1'b0, 1'b0};
        vecs[11] = '{16'h0000, 8'h00, 16'h7FFF, 1'b0, 1'b1};
        vecs[12] = '{16'h8000, 8'hF0, 16'h7FFF, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.num       = '0;
        bus.den       = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 32'(bus.in_ready), 32'd1);
        check("rst_vld", 32'(bus.out_valid), 32'd0);
        check("rst_quot", 32'(bus.quot), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Result held under back-pressure, new operands ignored.
        bus.out_ready = 1'b0;
        start_op(16'h0300, 8'h18, "stall");
        wait_result(lat);
        check("stall_lat", 32'(lat), 32'(LAT));
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.num      = 16'h0100;
            bus.den      = 8'h08;
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_quot", i), 32'(bus.quot), 32'h0200);
            check($sformatf("stall%0d_rdy", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("stall%0d_vld", i), 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_rdy", 32'(bus.in_ready), 32'd1);
        check("release_vld", 32'(bus.out_valid), 32'd0);
        v2 = '{16'h9C00, 8'h30, 16'hDEAB, 1'b0, 1'b0};
        run_vec(v2, "b2b");

        // Reset in the middle of a division discards it.
        start_op(16'h0300, 8'h18, "mid");
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
        check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        check("mid_rst_quot", 32'(bus.quot), 32'd0);
        run_vec(vecs[2], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
